// File: rtl/i2s_rx_deser.sv
// I2S ADC receiver: oversamples BCLK/WCLK/DOUT in the iCLK_50 domain and emits L/R words with a valid strobe.
// Optional short-word detection on frame_err is built when I2S_RX_FRAME_CHECK_EN is defined.
module i2s_rx_deser #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              iCLK_50,
    input  logic              iRESET_n,
    input  logic              i2s_sclk,
    input  logic              i2s_lrck,
    input  logic              i2s_sdout,
    output logic [DATA_W-1:0] L_data,
    output logic [DATA_W-1:0] R_data,
    output logic              sample_valid,
    output logic              frame_err
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t              CNT_MAX = cnt_t'(DATA_W);
    localparam logic [DATA_W-1:0] MSB_ONE = {1'b1, {(DATA_W-1){1'b0}}};

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] lrck_sync_q;
    logic [SYNC_STAGES-1:0] sdout_sync_q;
    logic                   sclk_dly_q;
    logic                   sclk_s;
    logic                   lrck_s;
    logic                   sdout_s;
    logic                   rise;

    always_ff @(posedge iCLK_50 or negedge iRESET_n) begin
        if (!iRESET_n) begin
            sclk_sync_q  <= '0;
            lrck_sync_q  <= '0;
            sdout_sync_q <= '0;
            sclk_dly_q   <= 1'b0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], i2s_sclk};
            lrck_sync_q  <= {lrck_sync_q[SYNC_STAGES-2:0], i2s_lrck};
            sdout_sync_q <= {sdout_sync_q[SYNC_STAGES-2:0], i2s_sdout};
            sclk_dly_q   <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign lrck_s  = lrck_sync_q[SYNC_STAGES-1];
    assign sdout_s = sdout_sync_q[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_dly_q;

    logic [DATA_W-1:0] shreg_q,   shreg_d;
    cnt_t              bit_cnt_q, bit_cnt_d;
    logic              lrck_prev_q, lrck_prev_d;
    logic              seen_q,    seen_d;
    logic              armed_q,   armed_d;
    logic [DATA_W-1:0] l_hold_q,  l_hold_d;
    logic [DATA_W-1:0] l_data_q,  l_data_d;
    logic [DATA_W-1:0] r_data_q,  r_data_d;
    logic              valid_q,   valid_d;

    logic              in_range;
    logic              boundary;
    logic [DATA_W-1:0] bit_sel;
    logic [DATA_W-1:0] shreg_wr;

    // bit_sel shifts out to zero once bit_cnt saturates, so padding bits never land in shreg.
    assign in_range = (bit_cnt_q < CNT_MAX);
    assign boundary = rise & (lrck_s != lrck_prev_q);
    assign bit_sel  = MSB_ONE >> bit_cnt_q;
    assign shreg_wr = sdout_s ? (shreg_q | bit_sel) : (shreg_q & ~bit_sel);

    always_comb begin
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        lrck_prev_d = lrck_prev_q;
        seen_d      = seen_q;
        armed_d     = armed_q;
        l_hold_d    = l_hold_q;
        l_data_d    = l_data_q;
        r_data_d    = r_data_q;
        valid_d     = 1'b0;
        if (rise) begin
            lrck_prev_d = lrck_s;
            if (boundary) begin
                // Boundary bit is the last bit of the closing word (one-bit I2S delay).
                shreg_d   = '0;
                bit_cnt_d = '0;
                seen_d    = 1'b1;
                if (lrck_s) begin
                    l_hold_d = shreg_wr;
                    // A left word only counts if it started on an observed boundary.
                    if (seen_q) armed_d = 1'b1;
                end else if (armed_q) begin
                    l_data_d = l_hold_q;
                    r_data_d = shreg_wr;
                    valid_d  = 1'b1;
                end
            end else if (in_range) begin
                shreg_d   = shreg_wr;
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK_50 or negedge iRESET_n) begin
        if (!iRESET_n) begin
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            lrck_prev_q <= 1'b0;
            seen_q      <= 1'b0;
            armed_q     <= 1'b0;
            l_hold_q    <= '0;
            l_data_q    <= '0;
            r_data_q    <= '0;
            valid_q     <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            lrck_prev_q <= lrck_prev_d;
            seen_q      <= seen_d;
            armed_q     <= armed_d;
            l_hold_q    <= l_hold_d;
            l_data_q    <= l_data_d;
            r_data_q    <= r_data_d;
            valid_q     <= valid_d;
        end
    end

    assign L_data       = l_data_q;
    assign R_data       = r_data_q;
    assign sample_valid = valid_q;

`ifdef I2S_RX_FRAME_CHECK_EN
    logic err_q, err_d;
    logic short_word;

    // Bits captured = bit_cnt plus the boundary bit when still in range.
    assign short_word = in_range & (bit_cnt_q < (CNT_MAX - cnt_t'(1)));

    always_comb begin
        err_d = err_q;
        if (boundary && seen_q && short_word) err_d = 1'b1;
    end

    always_ff @(posedge iCLK_50 or negedge iRESET_n) begin
        if (!iRESET_n) err_q <= 1'b0;
        else           err_q <= err_d;
    end

    assign frame_err = err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Bench for i2s_rx_deser: table vectors, startup/short-word/reset sequences and random max-rate frames vs a word-level model.
module tb_i2s_rx_deser;
    localparam int DW = 16;
    localparam int SS = 2;
`ifdef I2S_RX_FRAME_CHECK_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b1;
    logic sclk = 1'b0, lrck = 1'b0, sdout = 1'b0;
    logic [DW-1:0] L_data, R_data;
    logic sample_valid, frame_err;

    i2s_rx_deser #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .iCLK_50(clk), .iRESET_n(rst_n), .i2s_sclk(sclk), .i2s_lrck(lrck),
        .i2s_sdout(sdout), .L_data(L_data), .R_data(R_data),
        .sample_valid(sample_valid), .frame_err(frame_err));

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    logic [2*DW-1:0] got_q[$], exp_q[$];
    int              got_cyc[$], exp_cyc[$];
    logic            prev_v = 1'b0;

    always @(negedge clk) begin
        if (sample_valid === 1'b1) begin
            got_q.push_back({L_data, R_data});
            got_cyc.push_back(cyc);
            chk("valid_single_cycle", 64'(prev_v), 64'd0);
        end
        prev_v <= sample_valid;
    end

    // Word-level reference: a word is deliverable only if it began on a boundary seen since reset.
    logic          m_last, m_seen, m_lpend, m_err, prev_bit;
    logic [DW-1:0] m_lval, m_word;
    int            m_bits;

    function automatic logic [DW-1:0] captured(input logic [DW-1:0] w, input int n);
        logic [DW-1:0] mask;
        mask = '1;
        if (n < DW) mask = mask << (DW - n);
        return w & mask;
    endfunction

    task automatic model_reset();
        m_last = 1'b0; m_seen = 1'b0; m_lpend = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_rise(input logic lr);
        if (lr != m_last) begin
            if (m_seen) begin
                if (FC && m_bits < DW) m_err = 1'b1;
                if (lr) begin
                    m_lpend = 1'b1;
                    m_lval  = m_word;
                end else if (m_lpend) begin
                    exp_q.push_back({m_lval, m_word});
                    exp_cyc.push_back(cyc);
                end
            end
            m_seen = 1'b1;
            m_last = lr;
        end
    endtask

    task automatic rise(input logic lr, input logic sd, input int half);
        lrck = lr; sdout = sd;
        repeat (half) @(negedge clk);
        sclk = 1'b1;
        model_rise(lr);
        repeat (half) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_async_L", 64'(L_data), 64'd0);
        chk("rst_async_R", 64'(R_data), 64'd0);
        chk("rst_async_valid", 64'(sample_valid), 64'd0);
        chk("rst_async_err", 64'(frame_err), 64'd0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // One slot of n BCLK rises; data lags lrck by one rise.
    task automatic send_slot(input logic ch, input logic [DW-1:0] w, input int n,
                             input int half, input int rst_at);
        logic nb;
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) mid_reset();
            rise(ch, prev_bit, half);
            if (i == 0) begin
                m_word = captured(w, n);
                m_bits = (n < DW) ? n : DW;
            end
            nb = (i < DW) ? w[DW-1-i] : 1'($urandom_range(0, 1));
            prev_bit = nb;
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                              input int nl, input int nr, input int half);
        send_slot(1'b0, l, nl, half, -1);
        send_slot(1'b1, r, nr, half, -1);
    endtask

    task automatic clear_q();
        got_q.delete(); got_cyc.delete(); exp_q.delete(); exp_cyc.delete();
    endtask

    task automatic chk_pair(input string nm, input int k, input logic [DW-1:0] el,
                            input logic [DW-1:0] er);
        if (k < got_q.size()) begin
            chk({nm, "_L"}, 64'(got_q[k][2*DW-1:DW]), 64'(el));
            chk({nm, "_R"}, 64'(got_q[k][DW-1:0]), 64'(er));
        end else begin
            n_chk++; n_fail++;
            $display("FAIL %s: pulse %0d missing, expected %0h/%0h", nm, k, el, er);
        end
    endtask

    task automatic chk_model(input string nm);
        int m, d;
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        chk({nm, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < m; i++) begin
            chk({nm, "_sample"}, 64'(got_q[i]), 64'(exp_q[i]));
            d = got_cyc[i] - exp_cyc[i];
            n_chk++;
            if (d < SS + 1 || d > SS + 2) begin
                n_fail++;
                $display("FAIL %s_latency: got %0d cycles, expected %0d..%0d", nm, d, SS + 1, SS + 2);
            end
        end
    endtask

    typedef struct {
        logic [DW-1:0] l, r;
        int            nl, nr, half;
        logic [DW-1:0] el, er;
    } vec_t;
    vec_t tbl[5];

    initial begin
        tbl[0] = '{16'hA5C3, 16'h5A3C, 32, 32, 8, 16'hA5C3, 16'h5A3C};
        tbl[1] = '{16'h8001, 16'h7FFE, 16, 16, 8, 16'h8001, 16'h7FFE};
        tbl[2] = '{16'hFFFF, 16'h0000, 24, 20, 2, 16'hFFFF, 16'h0000};
        tbl[3] = '{16'h1234, 16'hFEDC, 17, 16, 3, 16'h1234, 16'hFEDC};
        tbl[4] = '{16'h0001, 16'h8000, 16, 32, 2, 16'h0001, 16'h8000};
        prev_bit = 1'b0; m_word = '0; m_lval = '0; m_bits = DW;
        model_reset();

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_L", 64'(L_data), 64'd0);
        chk("reset_R", 64'(R_data), 64'd0);
        chk("reset_valid", 64'(sample_valid), 64'd0);
        chk("reset_err", 64'(frame_err), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Table vectors, preceded by a right slot so the first left word is framed.
        clear_q();
        send_slot(1'b1, 16'h0, DW, 4, -1);
        foreach (tbl[k]) send_frame(tbl[k].l, tbl[k].r, tbl[k].nl, tbl[k].nr, tbl[k].half);
        send_slot(1'b0, 16'h0, DW, 4, -1);
        repeat (12) @(negedge clk);
        chk("tbl_count", 64'(got_q.size()), 64'd5);
        foreach (tbl[k]) chk_pair("tbl", k, tbl[k].el, tbl[k].er);
        chk_model("tbl_model");
        chk("tbl_frame_err", 64'(frame_err), 64'd0);

        // Startup: reset released mid right word.
        clear_q();
        send_slot(1'b1, 16'h0, DW, 4, 5);
        send_frame(16'h1111, 16'h2222, DW, DW, 4);
        send_slot(1'b0, 16'h0, DW, 4, -1);
        repeat (12) @(negedge clk);
        chk("startup_count", 64'(got_q.size()), 64'd1);
        chk_pair("startup", 0, 16'h1111, 16'h2222);

        // Short 12-bit left word.
        clear_q();
        send_slot(1'b1, 16'h9999, DW, 4, -1);
        send_slot(1'b0, 16'hABC0, 12, 4, -1);
        send_slot(1'b1, 16'h0F0F, DW, 4, -1);
        send_slot(1'b0, 16'h0, DW, 4, -1);
        repeat (12) @(negedge clk);
        chk("short_count", 64'(got_q.size()), 64'd2);
        chk_pair("short_prev", 0, 16'h0000, 16'h9999);
        chk_pair("short", 1, 16'hABC0, 16'h0F0F);
        chk("short_frame_err", 64'(frame_err), 64'(FC));
        send_frame(16'h1357, 16'h2468, DW, DW, 4);
        chk("frame_err_sticky", 64'(frame_err), 64'(m_err));

        // Reset while streaming, mid left word.
        send_slot(1'b0, 16'h5A5A, DW, 4, 6);
        clear_q();
        send_slot(1'b1, 16'h5555, DW, 4, -1);
        send_frame(16'h3333, 16'h4444, DW, DW, 4);
        send_slot(1'b0, 16'h0, DW, 4, -1);
        repeat (12) @(negedge clk);
        chk("rststream_count", 64'(got_q.size()), 64'd1);
        chk_pair("rststream", 0, 16'h3333, 16'h4444);
        chk("rststream_err", 64'(frame_err), 64'd0);

        // Random data at 12.5 MHz BCLK with varied slot lengths.
        clear_q();
        send_slot(1'b1, 16'($urandom), DW, 2, -1);
        for (int f = 0; f < 400; f++)
            send_frame(16'($urandom), 16'($urandom), $urandom_range(DW, DW + 4),
                       $urandom_range(DW, DW + 4), 2);
        send_slot(1'b0, 16'h0, DW, 2, -1);
        repeat (12) @(negedge clk);
        chk("rand_pulses", 64'(got_q.size()), 64'd401);
        chk_model("rand");
        chk("rand_frame_err", 64'(frame_err), 64'(m_err));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
